// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Operands are registered into the ALU, and results are returned through a one-deep response register.
module alu_rr_arbiter #(
  parameter int WIDTH = 64,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_bge,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_bge,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q;
  logic             last_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OP_W-1:0]  alu_op_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_bge_q;
  logic             rsp_id_q;

  logic win;
  logic gnt_v;
  logic gnt_id;
  logic fire;

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b01): begin
        gnt_v  = 1'b1;
        gnt_id = 1'b0;
      end
      (req_valid == 2'b10): begin
        gnt_v  = 1'b1;
        gnt_id = 1'b1;
      end
      (req_valid == 2'b11): begin
        gnt_v  = 1'b1;
        gnt_id = ~last_q;
      end
      default: begin
        gnt_v  = 1'b0;
        gnt_id = 1'b0;
      end
    endcase
  end

  // A retiring response frees the slot in the same cycle.
  assign win  = (state_q == IDLE) ||
                ((state_q == RESP) && rsp_ready);
  assign fire = win && gnt_v;

  assign req_ready = !fire ? 2'b00 :
                     gnt_id ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_bge_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      if (fire) begin
        alu_a_q  <= gnt_id ? req1_a : req0_a;
        alu_b_q  <= gnt_id ? req1_b : req0_b;
        alu_op_q <= gnt_id ? req1_op : req0_op;
        id_q     <= gnt_id;
        last_q   <= gnt_id;
      end
      unique case (state_q)
        IDLE: begin
          if (fire) state_q <= EXEC;
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          rsp_bge_q    <= alu_bge;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= fire ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_bge    = rsp_bge_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small behavioural ALU.
// It uses a vector table plus sequences for alternation, stall, reset, and idle.
module tb_alu_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_bge;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_zero, rsp_bge, rsp_id, busy;

  int checks = 0;
  int errors = 0;

  alu_rr_arbiter #(.WIDTH(64), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_bge(alu_bge),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_bge(rsp_bge), .rsp_id(rsp_id), .busy(busy)
  );

  always_comb begin
    alu_result = 64'd0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = 64'd0;
    endcase
    alu_zero = (alu_result == 64'd0);
    alu_bge  = ($signed(alu_a) >= $signed(alu_b));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [63:0] a0, b0;
    logic [3:0]  op0;
    logic [63:0] a1, b1;
    logic [3:0]  op1;
    logic [1:0]  rdy;
    logic [63:0] ea, eb;
    logic [63:0] res;
    logic        z, b, id;
  } vec_t;

  vec_t tv[7];

  initial begin
    tv[0] = '{2'b01, 64'd5, 64'd3, 4'b0010, 64'd0, 64'd0, 4'b0000,
              2'b01, 64'd5, 64'd3, 64'd8, 1'b0, 1'b1, 1'b0};
    tv[1] = '{2'b10, 64'd0, 64'd0, 4'b0000, 64'd2, 64'd7, 4'b0110,
              2'b10, 64'd2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFB,
              1'b0, 1'b0, 1'b1};
    tv[2] = '{2'b11, 64'd3, 64'd3, 4'b0110, 64'd6, 64'd1, 4'b0010,
              2'b01, 64'd3, 64'd3, 64'd0, 1'b1, 1'b1, 1'b0};
    tv[3] = '{2'b11, 64'd1, 64'd1, 4'b0010, 64'd9, 64'd4, 4'b0000,
              2'b10, 64'd9, 64'd4, 64'd0, 1'b1, 1'b1, 1'b1};
    tv[4] = '{2'b11, 64'hF0, 64'h0F, 4'b0001, 64'd2, 64'd2, 4'b0110,
              2'b01, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b1, 1'b0};
    tv[5] = '{2'b10, 64'd0, 64'd0, 4'b0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010,
              2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
              1'b1, 1'b0, 1'b1};
    tv[6] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 4'b0110,
              64'd0, 64'd0, 4'b0000,
              2'b01, 64'h8000_0000_0000_0000, 64'd1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst alu_a", alu_a, 64'd0);
    chk("rst alu_op", {60'd0, alu_op}, 64'd0);
    chk("rst rsp_result", rsp_result, 64'd0);
    chk("rst rsp_id", {63'd0, rsp_id}, 64'd0);

    rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_valid = tv[i].rv;
      req0_a = tv[i].a0; req0_b = tv[i].b0; req0_op = tv[i].op0;
      req1_a = tv[i].a1; req1_b = tv[i].b1; req1_op = tv[i].op1;
      #1 chk($sformatf("tv%0d req_ready", i), {62'd0, req_ready},
             {62'd0, tv[i].rdy});
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      chk($sformatf("tv%0d alu_a", i), alu_a, tv[i].ea);
      chk($sformatf("tv%0d alu_b", i), alu_b, tv[i].eb);
      chk($sformatf("tv%0d exec ready", i), {62'd0, req_ready}, 64'd0);
      chk($sformatf("tv%0d exec busy", i), {63'd0, busy}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tv%0d rsp_valid", i), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("tv%0d result", i), rsp_result, tv[i].res);
      chk($sformatf("tv%0d zero", i), {63'd0, rsp_zero},
          {63'd0, tv[i].z});
      chk($sformatf("tv%0d bge", i), {63'd0, rsp_bge},
          {63'd0, tv[i].b});
      chk($sformatf("tv%0d id", i), {63'd0, rsp_id},
          {63'd0, tv[i].id});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tv%0d retire", i), {63'd0, rsp_valid}, 64'd0);
      chk($sformatf("tv%0d idle", i), {63'd0, busy}, 64'd0);
    end

    // Both requesters are valid back to back, and the grants must alternate.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b11;
    req0_a = 64'd3; req0_b = 64'd3; req0_op = 4'b0110;
    req1_a = 64'd2; req1_b = 64'd7; req1_op = 4'b0110;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic e;
      e = k[0];
      #1 chk($sformatf("alt%0d ready", k), {62'd0, req_ready},
             e ? 64'd2 : 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("alt%0d exec ready", k), {62'd0, req_ready}, 64'd0);
      chk($sformatf("alt%0d alu_a", k), alu_a, e ? 64'd2 : 64'd3);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("alt%0d valid", k), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("alt%0d id", k), {63'd0, rsp_id}, {63'd0, e});
      chk($sformatf("alt%0d result", k), rsp_result,
          e ? 64'hFFFF_FFFF_FFFF_FFFB : 64'd0);
      chk($sformatf("alt%0d zero", k), {63'd0, rsp_zero},
          {63'd0, ~e});
      chk($sformatf("alt%0d bge", k), {63'd0, rsp_bge}, {63'd0, ~e});
    end
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("alt end busy", {63'd0, busy}, 64'd0);

    // The response stalls while requester 1 waits and changes operand a.
    req_valid = 2'b01;
    req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'b0010;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    req1_a = 64'd10; req1_b = 64'd1; req1_op = 4'b0010;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d valid", i), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("stall%0d result", i), rsp_result, 64'd8);
      chk($sformatf("stall%0d id", i), {63'd0, rsp_id}, 64'd0);
      chk($sformatf("stall%0d ready", i), {62'd0, req_ready}, 64'd0);
      chk($sformatf("stall%0d busy", i), {63'd0, busy}, 64'd1);
      chk($sformatf("stall%0d alu_a", i), alu_a, 64'd5);
      if (i == 1) req1_a = 64'd20;
    end
    rsp_ready = 1'b1;
    #1 chk("stall release ready", {62'd0, req_ready}, 64'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk("stall retired", {63'd0, rsp_valid}, 64'd0);
    chk("stall busy kept", {63'd0, busy}, 64'd1);
    chk("stall alu_a new", alu_a, 64'd20);
    chk("stall alu_b new", alu_b, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("stall r1 valid", {63'd0, rsp_valid}, 64'd1);
    chk("stall r1 result", rsp_result, 64'd21);
    chk("stall r1 id", {63'd0, rsp_id}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("stall end busy", {63'd0, busy}, 64'd0);

    // Reset during EXEC must clear state and restore priority to requester 0.
    req_valid = 2'b01;
    req0_a = 64'd7; req0_b = 64'd0; req0_op = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    chk("mid exec busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst busy", {63'd0, busy}, 64'd0);
    chk("mid rst valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid rst alu_a", alu_a, 64'd0);
    chk("mid rst alu_b", alu_b, 64'd0);
    chk("mid rst alu_op", {60'd0, alu_op}, 64'd0);
    chk("mid rst result", rsp_result, 64'd0);
    req_valid = 2'b11;
    req1_a = 64'd4; req1_b = 64'd4; req1_op = 4'b0110;
    #1 chk("mid rst tie ready", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    chk("post rst alu_a", alu_a, 64'd7);
    @(posedge clk);
    @(negedge clk);
    chk("post rst result", rsp_result, 64'd7);
    chk("post rst id", {63'd0, rsp_id}, 64'd0);
    chk("post rst bge", {63'd0, rsp_bge}, 64'd1);
    @(posedge clk);
    @(negedge clk);

    // Idle with no requests leaves all held values unchanged.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle%0d busy", i), {63'd0, busy}, 64'd0);
      chk($sformatf("idle%0d ready", i), {62'd0, req_ready}, 64'd0);
      chk($sformatf("idle%0d valid", i), {63'd0, rsp_valid}, 64'd0);
      chk($sformatf("idle%0d alu_a", i), alu_a, 64'd7);
      chk($sformatf("idle%0d held", i), rsp_result, 64'd7);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one 64-bit ALU instance between two requesters: requester 0 is the main datapath and requester 1 is an auxiliary unit such as a branch/address unit.
- Grants are round-robin. The block captures the granted operands, drives the ALU for one cycle, registers the result and zero/bge flags, and returns them with valid/ready handshakes.
- It sits between the requesters and the ALU's a/b/alu_op inputs and result/zero/bge outputs.

Parameters:
- WIDTH, 64, operand/result width.
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; one-hot or zero.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  OP_W  requester 0 opcode.
- req1_a, req1_b  in  WIDTH  requester 1 operands.
- req1_op  in  OP_W  requester 1 opcode.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_op  out  OP_W  registered opcode to the ALU.
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero, alu_bge  in  1  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero, rsp_bge  out  1  captured flags.
- rsp_id  out  1  requester that owns the response.
- busy  out  1  high when state is not IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Encoding is free.
- Reset values:
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_bge=0, rsp_id=0.
  - alu_a=0, alu_b=0, alu_op=0, busy=0.
- Reset mid-operation aborts everything. Any in-flight or unconsumed response is dropped with no handshake.
- Accept window: open when state==IDLE, or when state==RESP && rsp_ready==1.
- Grant logic (combinational, only inside the accept window):
  - Only req_valid[0] set: grant 0.
  - Only req_valid[1] set: grant 1.
  - Both set: grant = ~last_grant.
  - Neither set: no grant.
- req_ready[g]=1 only for the granted g. Outside the window, req_ready=2'b00.
- req_ready does not depend on the requesters' operands.
- Handshake fires when req_valid[g] && req_ready[g]. On that edge:
  - alu_a/alu_b/alu_op load the granted requester's a/b/op.
  - Grant id is stored internally; last_grant<=g; state<=EXEC.
- EXEC, exactly one cycle:
  - ALU sees the stable registered operands.
  - At the edge: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_bge<=alu_bge, rsp_id<=stored id, rsp_valid<=1, state<=RESP.
  - req_ready=0 during EXEC.
- RESP: rsp_* hold stable while rsp_valid=1 && rsp_ready=0.
  - rsp_ready=1 with no grant: rsp_valid<=0, state<=IDLE.
  - rsp_ready=1 with a grant (simultaneous retire and accept): rsp_valid<=0, new operands loaded, state<=EXEC.
- Latency: handshake at edge N, response valid after edge N+1. Best throughput is one operation per 2 cycles.
- alu_a/alu_b/alu_op hold their last values in IDLE/RESP; they change only on an accepted handshake.
- rsp_result/flags hold the last value after retirement; only rsp_valid qualifies them.
- A requester may hold req_valid while not granted. Its operands are sampled only on its own handshake.
- Fairness: with both requesters continuously valid, grants strictly alternate, so neither waits more than one foreign operation.
- Requests arriving during EXEC or a stalled RESP wait. No queueing beyond the single response register.
- busy = (state != IDLE).
- Width rules: no arithmetic in this block; results and flags pass through bit-exact.

Test Plan:
- Reset, then req_valid=2'b01, req0_a=5, req0_b=3, req0_op=4'b0010, rsp_ready=1 -> req_ready=2'b01 in cycle 0; next cycle alu_a=5, alu_b=3, alu_op=0010; following cycle rsp_valid=1, rsp_result=8, rsp_zero=0, rsp_bge=1, rsp_id=0.
- Both valid continuously, both with op=0110 (SUB), rsp_ready=1 -> grant order 0,1,0,1. req0: a=3, b=3 -> rsp_zero=1, rsp_bge=1. req1: a=2, b=7 -> result=64'hFFFF_FFFF_FFFF_FFFB, zero=0, bge=0.
- Response stall: rsp_ready=0 for 4 cycles after rsp_valid with req_valid=2'b10 pending -> rsp_* stable, req_ready=2'b00. Raising rsp_ready -> retire and accept requester 1 on the same edge, busy stays 1.
- Operand change while waiting: requester 1 changes a from 10 to 20 before its grant -> alu_a=20, and the value 10 never appears.
- Reset asserted during EXEC -> next cycle state IDLE, rsp_valid=0, alu_a/b/op=0, last_grant=1. Then both valid -> requester 0 is granted first.
- Idle with req_valid=0 for 10 cycles -> busy=0, req_ready=0, alu_* unchanged, rsp_valid=0.
